// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: request/result bundle for the shared adder.
// master drives operands/flush/res_ready; slave returns grants and result.
interface adder_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IP_W  = 16,
    parameter int OC_W  = 16,
    parameter int ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
);
    logic                   i_flush;
    logic [N_REQ-1:0]       i_req_valid;
    logic [N_REQ-1:0]       o_req_ready;
    logic [N_REQ*IP_W-1:0]  i_req_p;
    logic [N_REQ*OC_W-1:0]  i_req_c;
    logic                   o_res_valid;
    logic                   i_res_ready;
    logic [OC_W-1:0]        o_res_sum;
    logic [ID_W-1:0]        o_res_id;

    modport master (
        output i_flush, i_req_valid, i_req_p, i_req_c, i_res_ready,
        input  o_req_ready, o_res_valid, o_res_sum, o_res_id
    );

    modport slave (
        input  i_flush, i_req_valid, i_req_p, i_req_c, i_res_ready,
        output o_req_ready, o_res_valid, o_res_sum, o_res_id
    );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter feeding one p+c adder, 1-entry result reg.
// Ports: i_clk, i_rstn (async low), bus (adder_arbiter_if.slave).
// Macro SAURIA_ADDER_ARB_TRUNC_EN enables A_APPROX LSB truncation.
module adder_arbiter #(
    parameter int N_REQ    = 4,
    parameter int A_APPROX = 0,
    parameter int IP_W     = 16,
    parameter int OC_W     = 16
) (
    input logic            i_clk,
    input logic            i_rstn,
    adder_arbiter_if.slave bus
);
    localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;

`ifdef SAURIA_ADDER_ARB_TRUNC_EN
    localparam bit TRUNC_EN = 1'b1;
`else
    localparam bit TRUNC_EN = 1'b0;
`endif

    // Mask of LSBs forced before the add; zero gives the exact sum.
    localparam logic [OC_W-1:0] LSB_MASK =
        TRUNC_EN ? ((OC_W'(1) << A_APPROX) - OC_W'(1)) : '0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [OC_W-1:0]  res_sum;
    logic [ID_W-1:0]  res_id;
    logic [ID_W-1:0]  last_grant;

    logic             adder_free;
    logic             grant_en;
    logic             found;
    logic [ID_W-1:0]  sel;
    logic [ID_W:0]    cand;
    logic [IP_W-1:0]  p_sel;
    logic [OC_W-1:0]  c_sel;
    logic [OC_W-1:0]  p_ext;
    logic [OC_W-1:0]  sum_next;

    assign adder_free = (state == EMPTY) || bus.i_res_ready;
    assign grant_en   = i_rstn && adder_free && !bus.i_flush && found;

    // Round-robin search beginning just after the last granted index.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!found && bus.i_req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        bus.o_req_ready = '0;
        p_sel           = '0;
        c_sel           = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel == ID_W'(k)) begin
                bus.o_req_ready[k] = grant_en;
                p_sel = bus.i_req_p[k*IP_W +: IP_W];
                c_sel = bus.i_req_c[k*OC_W +: OC_W];
            end
        end
    end

    assign p_ext    = OC_W'($signed(p_sel));
    assign sum_next = (p_ext | LSB_MASK) + (c_sel & ~LSB_MASK);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= EMPTY;
            res_sum    <= '0;
            res_id     <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else if (bus.i_flush) begin
            state <= EMPTY;
        end else if (grant_en) begin
            state      <= FULL;
            res_sum    <= sum_next;
            res_id     <= sel;
            last_grant <= sel;
        end else if (state == FULL && bus.i_res_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.o_res_valid = (state == FULL);
    assign bus.o_res_sum   = res_sum;
    assign bus.o_res_id    = res_id;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: random + directed checks of adder_arbiter against a model.
// Second instance (IP_W=8, N_REQ=3) exercises sign extension.
module tb_adder_arbiter;
`ifdef SAURIA_ADDER_ARB_TRUNC_EN
    localparam int T = 4;
`else
    localparam int T = 0;
`endif

    logic clk;
    logic rstn;

    adder_arbiter_if #(.N_REQ(4), .IP_W(16), .OC_W(16)) bus_a ();
    adder_arbiter_if #(.N_REQ(3), .IP_W(8),  .OC_W(16)) bus_b ();

    adder_arbiter #(
        .N_REQ(4), .A_APPROX(4), .IP_W(16), .OC_W(16)
    ) u_dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus_a)
    );

    adder_arbiter #(
        .N_REQ(3), .A_APPROX(0), .IP_W(8), .OC_W(16)
    ) u_nar (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] pa [4];
    logic [15:0] ca [4];

    bit          m_full;
    logic [15:0] m_sum;
    int          m_id;
    int          m_last;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_add(input logic [15:0] p,
                                            input logic [15:0] c);
        logic [15:0] m;
        m = 16'((1 << T) - 1);
        return (p | m) + (c & ~m);
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] p,
                                         input logic [15:0] c);
        int ps;
        int s;
        ps = (p > 8'd127) ? int'(p) - 256 : int'(p);
        s  = ps + int'(c);
        return s[15:0];
    endfunction

    task automatic drive();
        bus_a.i_req_p = {pa[3], pa[2], pa[1], pa[0]};
        bus_a.i_req_c = {ca[3], ca[2], ca[1], ca[0]};
    endtask

    task automatic cycle();
        int g;
        logic [3:0] er;
        drive();
        #1;
        g  = -1;
        er = '0;
        if (rstn && !bus_a.i_flush && (!m_full || bus_a.i_res_ready)) begin
            for (int i = 1; i <= 4; i++) begin
                int k;
                k = (m_last + i) % 4;
                if (g < 0 && bus_a.i_req_valid[k]) g = k;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(bus_a.o_req_ready), 32'(er));
        @(posedge clk);
        if (bus_a.i_flush) begin
            m_full = 1'b0;
        end else if (g >= 0) begin
            m_full = 1'b1;
            m_sum  = ref_add(pa[g], ca[g]);
            m_id   = g;
            m_last = g;
        end else if (m_full && bus_a.i_res_ready) begin
            m_full = 1'b0;
        end
        #1;
        check("res_valid", 32'(bus_a.o_res_valid), 32'(m_full));
        check("res_sum", 32'(bus_a.o_res_sum), 32'(m_sum));
        check("res_id", 32'(bus_a.o_res_id), 32'(m_id));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus_a.i_req_valid = 4'hF;
        #1;
        check("rst_ready", 32'(bus_a.o_req_ready), 32'h0);
        check("rst_valid", 32'(bus_a.o_res_valid), 32'h0);
        check("rst_sum", 32'(bus_a.o_res_sum), 32'h0);
        check("rst_id", 32'(bus_a.o_res_id), 32'h0);
        check("rst_b_valid", 32'(bus_b.o_res_valid), 32'h0);
        m_full = 1'b0;
        m_sum  = '0;
        m_id   = 0;
        m_last = 3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        bus_a.i_req_valid = '0;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) begin
            pa[i] = 16'($urandom);
            ca[i] = 16'($urandom);
        end
    endtask

    task automatic nar_op(input int k, input logic [7:0] p,
                          input logic [15:0] c, input logic [15:0] exp);
        bus_b.i_req_valid = 3'(1 << k);
        bus_b.i_req_p = '0;
        bus_b.i_req_c = '0;
        bus_b.i_req_p[k*8 +: 8]   = p;
        bus_b.i_req_c[k*16 +: 16] = c;
        @(posedge clk);
        #1;
        check("nar_valid", 32'(bus_b.o_res_valid), 32'h1);
        check("nar_sum", 32'(bus_b.o_res_sum), 32'(exp));
        check("nar_id", 32'(bus_b.o_res_id), 32'(k));
        bus_b.i_req_valid = '0;
    endtask

    initial begin
        rstn = 1'b0;
        bus_a.i_flush     = 1'b0;
        bus_a.i_req_valid = '0;
        bus_a.i_res_ready = 1'b1;
        bus_b.i_flush     = 1'b0;
        bus_b.i_req_valid = '0;
        bus_b.i_req_p     = '0;
        bus_b.i_req_c     = '0;
        bus_b.i_res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pa[i] = '0;
            ca[i] = '0;
        end
        drive();
        do_reset();

        // Truncation vector on requester 0
        bus_a.i_req_valid = 4'b0001;
        pa[0] = 16'h0013;
        ca[0] = 16'h0021;
        cycle();
        check("trunc_vec", 32'(bus_a.o_res_sum), (T > 0) ? 32'h3F : 32'h34);
        bus_a.i_req_valid = '0;
        cycle();

        // Continuous round-robin from reset
        do_reset();
        bus_a.i_req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            cycle();
            check("rr_seq", 32'(bus_a.o_res_id), 32'(i % 4));
            check("rr_valid", 32'(bus_a.o_res_valid), 32'h1);
        end

        // Back-pressure: hold then release
        bus_a.i_res_ready = 1'b0;
        repeat (5) begin
            rand_ops();
            cycle();
        end
        bus_a.i_res_ready = 1'b1;
        cycle();
        check("bp_release_id", 32'(bus_a.o_res_id), 32'h0);

        // Flush while full with req2 pending
        bus_a.i_req_valid = 4'b0100;
        bus_a.i_flush = 1'b1;
        cycle();
        check("flush_valid", 32'(bus_a.o_res_valid), 32'h0);
        bus_a.i_flush = 1'b0;
        cycle();
        check("flush_regrant", 32'(bus_a.o_res_id), 32'h2);

        // Asynchronous reset mid-stream
        bus_a.i_req_valid = 4'hF;
        repeat (3) begin
            rand_ops();
            cycle();
        end
        do_reset();
        bus_a.i_req_valid = 4'hF;
        cycle();
        check("post_rst_grant", 32'(bus_a.o_res_id), 32'h0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rand_ops();
            bus_a.i_req_valid = 4'($urandom);
            bus_a.i_res_ready = ($urandom % 4) != 0;
            bus_a.i_flush     = ($urandom % 16) == 0;
            cycle();
        end
        bus_a.i_flush     = 1'b0;
        bus_a.i_req_valid = '0;

        // Narrow-operand sign extension and wrap
        nar_op(0, 8'hFF, 16'h0005, 16'h0004);
        nar_op(0, 8'h7F, 16'h7FFF, 16'h807E);
        for (int n = 0; n < 12; n++) begin
            logic [7:0]  p;
            logic [15:0] c;
            int k;
            p = 8'($urandom);
            c = 16'($urandom);
            k = int'($urandom % 3);
            nar_op(k, p, c, ref8(p, c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one adder (2..16).
REQ-002 SHALL have parameter A_APPROX, default 0: number of truncated result LSBs (0..OC_W-1).
REQ-003 SHALL have parameter IP_W, default 16: partial-product operand width.
REQ-004 SHALL have parameter OC_W, default 16: accumulator operand and result width, OC_W >= IP_W.
REQ-005 SHALL have port i_clk  input  1  single clock, all state rising-edge.
REQ-006 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_flush  input  1  synchronous discard of the held result.
REQ-008 SHALL have port i_req_valid  input  N_REQ  per-requester operand valid.
REQ-009 SHALL have port o_req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero.
REQ-010 SHALL have port i_req_p  input  N_REQ*IP_W  packed signed p operands, requester k at bits [k*IP_W +: IP_W].
REQ-011 SHALL have port i_req_c  input  N_REQ*OC_W  packed signed c operands, same packing.
REQ-012 SHALL have port o_res_valid  output  1  result register holds a valid sum.
REQ-013 SHALL have port i_res_ready  input  1  downstream accepts result.
REQ-014 SHALL have port o_res_sum  output  OC_W  registered sum.
REQ-015 SHALL have port o_res_id  output  max(1,$clog2(N_REQ))  index of the requester that produced o_res_sum.

Function
REQ-016 SHALL hold a one-entry result register with states EMPTY (o_res_valid=0) and FULL (o_res_valid=1).
REQ-017 SHALL consider the adder free in a cycle when state is EMPTY, or FULL with i_res_ready=1 (pop and refill same cycle).
REQ-018 SHALL, when the adder is free, i_flush=0 and any i_req_valid is set, assert o_req_ready for exactly one requester chosen round-robin; otherwise o_req_ready=0.
REQ-019 SHALL search round-robin starting at index (last_grant+1) mod N_REQ; last_grant updates only on an accepted transfer (valid and ready).
REQ-020 SHALL compute o_req_ready combinationally from i_req_valid, state, i_res_ready and i_flush; it SHALL NOT depend on operand data.
REQ-021 SHALL register sum and granted index on the accepting edge: 1-cycle latency, full throughput of one sum per cycle.
REQ-022 SHALL sign-extend p to OC_W and compute sum = p + c modulo 2^OC_W (wrap, no saturation, no overflow flag).
REQ-023 SHALL, when truncation is compiled in and A_APPROX>0, force p bits [A_APPROX-1:0] to 1 and c bits [A_APPROX-1:0] to 0 before adding; result LSBs [A_APPROX-1:0] are therefore all 1.
REQ-024 SHALL keep o_res_sum and o_res_id stable while FULL and i_res_ready=0.
REQ-025 SHALL transition FULL->EMPTY on pop without grant, EMPTY->FULL on grant, FULL->FULL on pop plus grant.
REQ-026 SHALL, on i_flush=1, go to EMPTY next cycle, grant nothing that cycle, and leave last_grant unchanged; flush has priority over pop and grant.

Reset
REQ-027 SHALL on i_rstn=0 asynchronously set state EMPTY, o_res_valid=0, o_res_sum=0, o_res_id=0, last_grant=N_REQ-1 (first search starts at requester 0).
REQ-028 SHALL force o_req_ready=0 while i_rstn=0; a transfer in flight at reset assertion is lost.

Configuration
REQ-029 SHALL compile the LSB truncation of REQ-023 only when macro SAURIA_ADDER_ARB_TRUNC_EN is defined.
REQ-030 SHALL, without SAURIA_ADDER_ARB_TRUNC_EN, compute exact p + c regardless of A_APPROX.

Verification
REQ-031 SHALL cover: IP_W=OC_W=16, A_APPROX=4, macro defined, req0 p=0x0013 c=0x0021 -> next cycle o_res_sum=0x003F, o_res_id=0; macro undefined -> 0x0034.
REQ-032 SHALL cover: IP_W=8, OC_W=16, A_APPROX=0, p=0xFF c=0x0005 -> o_res_sum=0x0004; p=0x7F c=0x7FFF -> 0x807E (wrap).
REQ-033 SHALL cover: N_REQ=4, all valid continuously, i_res_ready=1 after reset -> grants 0,1,2,3,0,... one per cycle, o_res_valid=1 every cycle from cycle 2.
REQ-034 SHALL cover: FULL with i_res_ready=0 for 5 cycles, all requesters valid -> o_req_ready=0, o_res_sum/o_res_id unchanged; on i_res_ready=1 grant goes to last_grant+1 in that same cycle.
REQ-035 SHALL cover: i_flush=1 while FULL and req2 valid -> no grant, o_res_valid=0 next cycle; then req2 granted next cycle.
REQ-036 SHALL cover: i_rstn deasserted mid-stream -> o_res_valid=0, o_res_sum=0 immediately (asynchronous); after release first grant is requester 0.
